// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: combinational instruction-memory lookup feeding
// a small in-order response FIFO, with branch flush and a program-load write port.
module instr_fetch_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic                  rsp_err,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [CNT_W-1:0]    FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  // Instruction memory (not reset; contents survive reset_n)
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  rd_in_range;
  logic                  wr_in_range;
  logic [DATA_WIDTH-1:0] rd_instr;
  logic                  rd_err;

  // Response FIFO storage and control
  logic [ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
  logic                  fifo_err_q   [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic not_full;
  logic push;
  logic pop;

  assign rd_in_range = ({1'b0, req_addr} < MEM_LIMIT);
  assign wr_in_range = ({1'b0, wr_addr}  < MEM_LIMIT);

  always_ff @(posedge clk) begin
    if (reset_n && wr_en && wr_in_range) begin
      mem_q[wr_addr[MIDX_W-1:0]] <= wr_data;
    end
  end

  // Read is combinational, so an accept colliding with a write sees the old word.
  always_comb begin
    rd_err   = ~rd_in_range;
    rd_instr = '0;
    if (rd_in_range) begin
      rd_instr = mem_q[req_addr[MIDX_W-1:0]];
    end
  end

  assign not_full  = (count_q != FULL_CNT);
  assign rsp_valid = (count_q != '0);
  assign req_ready = reset_n & ~flush & (not_full | rsp_ready);
  assign push      = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= req_addr;
      fifo_instr_q[wr_ptr_q] <= rd_instr;
      fifo_err_q[wr_ptr_q]   <= rd_err;
    end
  end

  always_comb begin
    rsp_addr  = '0;
    rsp_instr = '0;
    rsp_err   = 1'b0;
    if (rsp_valid) begin
      rsp_addr  = fifo_addr_q[rd_ptr_q];
      rsp_instr = fifo_instr_q[rd_ptr_q];
      rsp_err   = fifo_err_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder: reference queue of expected responses,
// checked every cycle at the falling edge.
module tb_instr_fetch_responder;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 200;
  localparam int unsigned FDEP  = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          flush;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_instr;
  logic          rsp_err;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] instr;
    logic          err;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] model_mem [256];
  int            checks = 0;
  int            errors = 0;

  instr_fetch_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH),
    .FIFO_DEPTH(FDEP)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .flush    (flush),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_addr (rsp_addr),
    .rsp_instr(rsp_instr),
    .rsp_err  (rsp_err),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge, then advance the reference at posedge.
  task automatic cycle();
    rsp_t e;
    logic exp_rdy, exp_vld, acc, pop;
    @(negedge clk);
    exp_vld = (exp_q.size() > 0);
    exp_rdy = reset_n & ~flush & ((exp_q.size() < FDEP) | rsp_ready);
    chk("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_vld});
    if (exp_vld) begin
      chk("rsp_addr",  {24'd0, rsp_addr},  {24'd0, exp_q[0].addr});
      chk("rsp_instr", {16'd0, rsp_instr}, {16'd0, exp_q[0].instr});
      chk("rsp_err",   {31'd0, rsp_err},   {31'd0, exp_q[0].err});
    end else begin
      chk("idle_addr",  {24'd0, rsp_addr},  32'd0);
      chk("idle_instr", {16'd0, rsp_instr}, 32'd0);
      chk("idle_err",   {31'd0, rsp_err},   32'd0);
    end
    acc = req_valid & exp_rdy;
    pop = exp_vld & rsp_ready;
    @(posedge clk);
    if (!reset_n || flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        e.addr  = req_addr;
        e.err   = (int'(req_addr) >= DEPTH);
        e.instr = e.err ? '0 : model_mem[req_addr];
        exp_q.push_back(e);
      end
    end
    if (reset_n && wr_en && int'(wr_addr) < DEPTH) model_mem[wr_addr] = wr_data;
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    rsp_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle_inputs();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic rdy);
    req_valid = 1'b1; req_addr = a; rsp_ready = rdy;
    cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    cycle();
    cycle();
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) load(AW'(i), 16'h1000 + DW'(i));
    load(8'd5, 16'h5005);
    load(8'd7, 16'hAAAA);
    load(8'd9, 16'h1234);

    // Streaming with consumer always ready
    for (int i = 0; i < 4; i++) fetch(AW'(i), 1'b1);
    req_valid = 1'b0;
    cycle();
    cycle();

    // Backpressure: third request stalls until the head pops
    fetch(8'd0, 1'b0);
    fetch(8'd1, 1'b0);
    fetch(8'd2, 1'b0);
    fetch(8'd2, 1'b1);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Flush with two queued responses and a request pending
    rsp_ready = 1'b0;
    fetch(8'd1, 1'b0);
    fetch(8'd2, 1'b0);
    flush = 1'b1;
    fetch(8'd3, 1'b0);
    flush = 1'b0;
    fetch(8'd5, 1'b1);
    req_valid = 1'b0;
    cycle();
    cycle();

    // Out-of-range fetch and write
    load(8'd250, 16'hBEEF);
    fetch(8'd250, 1'b1);
    req_valid = 1'b0;
    cycle();

    // Write/read collision returns the old word
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 16'h5555;
    fetch(8'd7, 1'b1);
    wr_en = 1'b0;
    fetch(8'd7, 1'b1);
    req_valid = 1'b0;
    cycle();
    cycle();

    // Reset with a full FIFO; the write during reset must be ignored
    fetch(8'd0, 1'b0);
    fetch(8'd1, 1'b0);
    reset_n = 1'b0;
    wr_en = 1'b1; wr_addr = 8'd9; wr_data = 16'hDEAD;
    fetch(8'd2, 1'b0);
    reset_n = 1'b1;
    idle_inputs();
    cycle();
    fetch(8'd0, 1'b1);
    fetch(8'd9, 1'b1);
    req_valid = 1'b0;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
